// File: rtl/disp_scan_sched.sv
// disp_scan_sched: multiplexed 14-segment display scanner with a writable
// character buffer. Optional message rotation is compiled in with the
// DISP_SCROLL_EN macro; without it scroll_en is ignored and wr_ready is
// constantly 1 after reset.
module disp_scan_sched #(
  parameter int unsigned DIGITS        = 12,
  parameter int unsigned PRESCALE      = 1000,
  parameter int unsigned SCROLL_FRAMES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [3:0]        wr_addr,
  input  logic [13:0]       wr_char,
  input  logic              blank,
  input  logic              scroll_en,
  output logic [DIGITS-1:0] sel,
  output logic [13:0]       segm,
  output logic              wr_err
);

  localparam int unsigned SEG_W = 14;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [SEG_W-1:0]  char_q [DIGITS];
  logic [SEG_W-1:0]  char_d [DIGITS];
  logic [DIGITS-1:0] sel_q, sel_d;
  logic [SEG_W-1:0]  segm_q, segm_d;
  logic              wr_err_q, wr_err_d;
  logic              wr_ready_q, wr_ready_d;

  logic              tick_c;
  logic              frame_end_c;
  logic              wr_fire_c;
  logic              addr_ok_c;
  logic              shift_c;
  logic [SEG_W-1:0]  cur_char_c;

  // Shared decode: slot tick, frame end, handshake and address range
  always_comb begin
    tick_c      = (pre_q == PRE_W'(PRESCALE - 1));
    frame_end_c = tick_c && (idx_q == IDX_W'(DIGITS - 1));
    wr_fire_c   = wr_valid && wr_ready_q;
    addr_ok_c   = (32'(wr_addr) < DIGITS);
  end

  // Character currently addressed by the scan index
  always_comb begin
    cur_char_c = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx_q == IDX_W'(i)) cur_char_c = char_q[i];
    end
  end

  // Prescaler, scan index and registered digit/segment drive
  always_comb begin
    pre_d  = pre_q + PRE_W'(1);
    idx_d  = idx_q;
    sel_d  = sel_q;
    segm_d = segm_q;
    if (tick_c) begin
      pre_d  = '0;
      idx_d  = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      sel_d  = blank ? '0 : (DIGITS'(1) << idx_q);
      segm_d = cur_char_c;
    end
  end

`ifdef DISP_SCROLL_EN
  localparam int unsigned FRM_W = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

  typedef enum logic {
    ST_SCAN  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [FRM_W-1:0] frame_q, frame_d;

  // Scroll FSM: count frame ends, request one shift cycle on the last one
  always_comb begin
    state_d    = ST_SCAN;
    frame_d    = frame_q;
    wr_ready_d = 1'b1;
    if (frame_end_c) begin
      if (frame_q == FRM_W'(SCROLL_FRAMES - 1)) begin
        frame_d = '0;
        if (scroll_en) begin
          state_d    = ST_SHIFT;
          wr_ready_d = 1'b0;
        end
      end else begin
        frame_d = frame_q + FRM_W'(1);
      end
    end
    shift_c = (state_q == ST_SHIFT);
  end

  // Scroll state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_SCAN;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
    end
  end
`else
  logic unused_scroll_en;

  // No rotation: writes are always accepted once out of reset
  always_comb begin
    shift_c          = 1'b0;
    wr_ready_d       = 1'b1;
    unused_scroll_en = scroll_en;
  end
`endif

  // Buffer update: rotate left in a shift cycle, else apply accepted writes
  always_comb begin
    char_d   = char_q;
    wr_err_d = wr_err_q | (wr_fire_c & ~addr_ok_c);
    if (shift_c) begin
      for (int i = 0; i < int'(DIGITS) - 1; i++) begin
        char_d[i] = char_q[i+1];
      end
      char_d[DIGITS-1] = char_q[0];
    end else if (wr_fire_c && addr_ok_c) begin
      for (int i = 0; i < int'(DIGITS); i++) begin
        if (wr_addr == 4'(i)) char_d[i] = wr_char;
      end
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q      <= '0;
      idx_q      <= '0;
      sel_q      <= '0;
      segm_q     <= '0;
      wr_err_q   <= 1'b0;
      wr_ready_q <= 1'b0;
      for (int i = 0; i < int'(DIGITS); i++) begin
        char_q[i] <= '0;
      end
    end else begin
      pre_q      <= pre_d;
      idx_q      <= idx_d;
      sel_q      <= sel_d;
      segm_q     <= segm_d;
      wr_err_q   <= wr_err_d;
      wr_ready_q <= wr_ready_d;
      char_q     <= char_d;
    end
  end

  assign sel      = sel_q;
  assign segm     = segm_q;
  assign wr_err   = wr_err_q;
  assign wr_ready = wr_ready_q;

endmodule
